// File: rtl/mult8_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential 8x8 multiplier.
// The master offers operands and consumes products; the slave is the controller.
interface mult8_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/mult8_seq_ctrl.sv
// 8x8 unsigned multiply built from four passes through one external 4x4 core.
// state | meaning
// IDLE  | ready for a new operand pair
// MUL   | one partial product per cycle, step 0..3 selects nibbles and shift
// DONE  | product presented until the consumer takes it
module mult8_seq_ctrl (
  input  logic                  clk,
  input  logic                  rst_n,
  mult8_seq_ctrl_if.slave       bus,
  output logic                  busy_o,
  output logic [3:0]            mul_x_o,
  output logic [3:0]            mul_y_o,
  input  logic [7:0]            mul_o_i
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] addend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      acc_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    mul_x_o = 4'd0;
    mul_y_o = 4'd0;
    addend  = 16'd0;

    // Core operands and weight depend only on the registered operands and step.
    if (state_q == MUL) begin
      case (step_q)
        2'd0: begin
          mul_x_o = a_q[3:0];
          mul_y_o = b_q[3:0];
          addend  = {8'd0, mul_o_i};
        end
        2'd1: begin
          mul_x_o = a_q[7:4];
          mul_y_o = b_q[3:0];
          addend  = {4'd0, mul_o_i, 4'd0};
        end
        2'd2: begin
          mul_x_o = a_q[3:0];
          mul_y_o = b_q[7:4];
          addend  = {4'd0, mul_o_i, 4'd0};
        end
        default: begin
          mul_x_o = a_q[7:4];
          mul_y_o = b_q[7:4];
          addend  = {mul_o_i, 8'd0};
        end
      endcase
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = 16'd0;
          step_d  = 2'd0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d  = acc_q + addend;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.product   = acc_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Scoreboard bench for mult8_seq_ctrl: accepted operand pairs queue a*b,
// a separate monitor pops and compares on every product handshake.
module tb_mult8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [3:0]  mx, my;
  logic [7:0]  mo;

  always #5 clk = ~clk;

  mult8_seq_ctrl_if ifc ();

  mult8_seq_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ifc),
    .busy_o  (busy),
    .mul_x_o (mx),
    .mul_y_o (my),
    .mul_o_i (mo)
  );

  // External combinational 4x4 core
  assign mo = {4'd0, mx} * {4'd0, my};

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          pop_cnt = 0;
  int          last_acc = -1;
  bit          b2b = 1'b0;
  int          ordy_mode = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_prod = 16'd0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_prod = 16'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready driver: 0 = always ready, 1 = random stalls, 2 = held low
  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ordy_mode)
        0: ifc.out_ready = 1'b1;
        1: ifc.out_ready = ($urandom_range(0, 3) != 0);
        default: ifc.out_ready = 1'b0;
      endcase
    end
  end

  // Reference model: every accepted pair must eventually yield a*b, in order
  always @(negedge clk) begin
    if (rst_n && ifc.in_valid && ifc.in_ready) begin
      exp_q.push_back({8'd0, ifc.a} * {8'd0, ifc.b});
      if (b2b && last_acc >= 0) chk("b2b_spacing", cyc - last_acc, 6);
      last_acc = cyc;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("hold_valid", ifc.out_valid, 1);
        chk("hold_product", ifc.product, prev_prod);
      end
      if (ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %0h want none", ifc.product);
        end else begin
          chk("product", ifc.product, exp_q.pop_front());
        end
        last_prod = ifc.product;
        pop_cnt++;
      end
      prev_stall = ifc.out_valid && !ifc.out_ready;
      prev_prod  = ifc.product;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(input logic [7:0] av, input logic [7:0] bv);
    ifc.a = av;
    ifc.b = bv;
    ifc.in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ifc.in_ready && rst_n) begin
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL accept_timeout: got no in_ready want accept of %0h*%0h", av, bv);
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string nm, input int n, input logic [15:0] exp);
    for (int t = 0; t < 200; t++) begin
      if (pop_cnt > n) break;
      @(posedge clk);
    end
    if (pop_cnt > n) chk(nm, last_prod, exp);
    else begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no product want %0h", nm, exp);
    end
  endtask

  logic [3:0]  trace_x [4];
  logic [3:0]  trace_y [4];
  logic [15:0] p0;
  int          n;
  bit          seen;

  initial begin
    trace_x[0] = 4'h5; trace_x[1] = 4'hA; trace_x[2] = 4'h5; trace_x[3] = 4'hA;
    trace_y[0] = 4'hC; trace_y[1] = 4'hC; trace_y[2] = 4'h3; trace_y[3] = 4'h3;
    ifc.in_valid = 1'b0;
    ifc.a = 8'd0;
    ifc.b = 8'd0;

    // Reset, with in_valid high to confirm it is not accepted
    rst_n = 1'b0;
    ifc.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", ifc.product, 0);
    chk("rst_mul_x", mx, 0);
    chk("rst_mul_y", my, 0);

    // Nibble trace and latency; operands scrambled after accept
    @(posedge clk);
    #1;
    n = pop_cnt;
    send(8'hA5, 8'h3C);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("trace_mul_x", mx, trace_x[k]);
      chk("trace_mul_y", my, trace_y[k]);
      chk("trace_busy", busy, 1);
      chk("trace_out_valid_low", ifc.out_valid, 0);
      ifc.a = 8'($urandom);
      ifc.b = 8'($urandom);
    end
    @(negedge clk);
    chk("latency_out_valid", ifc.out_valid, 1);
    chk("done_mul_x", mx, 0);
    chk("done_mul_y", my, 0);
    wait_result("prod_a5x3c", n, 16'h26AC);

    n = pop_cnt; send(8'hFF, 8'hFF); wait_result("prod_ffxff", n, 16'hFE01);
    n = pop_cnt; send(8'h00, 8'hAB); wait_result("prod_00xab", n, 16'h0000);
    n = pop_cnt; send(8'h12, 8'h34); wait_result("prod_12x34", n, 16'h03A8);

    // Backpressure: three stalled DONE cycles, then release
    ordy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    n = pop_cnt;
    send(8'h5A, 8'hC3);
    seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (ifc.out_valid) begin seen = 1'b1; break; end
    end
    chk("bp_reach_done", seen, 1);
    p0 = ifc.product;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", ifc.out_valid, 1);
      chk("bp_product", ifc.product, p0);
    end
    ordy_mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", ifc.in_ready, 1);
    chk("bp_idle_out_valid", ifc.out_valid, 0);
    wait_result("prod_5axc3", n, 16'h448E);

    // Reset at step 2 aborts the operation
    @(posedge clk);
    #1;
    send(8'h77, 8'h99);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_in_ready", ifc.in_ready, 1);
    chk("abort_out_valid", ifc.out_valid, 0);
    chk("abort_product", ifc.product, 0);
    chk("abort_busy", busy, 0);
    n = pop_cnt; send(8'h0F, 8'hF0); wait_result("prod_after_abort", n, 16'h0E10);

    // Back-to-back with operands changing every cycle
    @(posedge clk);
    #1;
    last_acc = -1;
    b2b = 1'b1;
    ifc.in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      ifc.a = 8'($urandom);
      ifc.b = 8'($urandom);
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
    b2b = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Random operands with random consumer stalls
    ordy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(8'($urandom), 8'($urandom));
    end
    ordy_mode = 0;
    for (int t = 0; t < 200; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish want finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult8_seq_ctrl.md
MULT8_SEQ_CTRL -- requirements
Module: mult8_seq_ctrl

Interface
REQ-001 No parameters; block is fixed at 8x8 operands on one shared 4x4 unsigned multiplier core.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 in_valid  in  1  operand pair offered.
REQ-006 in_ready  out  1  controller can accept operands.
REQ-007 a  in  8  unsigned multiplicand.
REQ-008 b  in  8  unsigned multiplier.
REQ-009 out_valid  out  1  product available.
REQ-010 out_ready  in  1  consumer accepts product.
REQ-011 product  out  16  unsigned a*b.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 mul_x  out  4  x operand to the external combinational 4x4 core.
REQ-014 mul_y  out  4  y operand to the external combinational 4x4 core.
REQ-015 mul_o  in  8  product from the core, valid in the same cycle as mul_x/mul_y.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, MUL and DONE, plus a 2-bit step counter used in MUL.
REQ-017 in_ready SHALL be 1 only in IDLE; an accept occurs at a rising edge with in_valid=1 and in_ready=1.
REQ-018 On accept, the block SHALL register a and b, clear the accumulator, set step=0 and enter MUL; a/b changes after accept are ignored.
REQ-019 In MUL the core operands SHALL be driven from registered operands: step0 (a[3:0],b[3:0]) shift 0; step1 (a[7:4],b[3:0]) shift 4; step2 (a[3:0],b[7:4]) shift 4; step3 (a[7:4],b[7:4]) shift 8.
REQ-020 Each MUL cycle SHALL add ({8'b0,mul_o} << shift) into the 16-bit accumulator at the clock edge and increment step.
REQ-021 Accumulation SHALL be unsigned mod 2^16; for 8-bit operands it never wraps.
REQ-022 After the step3 edge, the FSM SHALL enter DONE with out_valid=1 and product=accumulator; latency from accept edge to out_valid visible is 4 cycles.
REQ-023 In DONE, product and out_valid SHALL hold stable while out_ready=0.
REQ-024 In DONE with out_ready=1, the FSM SHALL return to IDLE at that edge; out_valid=0 next cycle; no new accept in that same cycle.
REQ-025 In IDLE and DONE, mul_x and mul_y SHALL be 0.
REQ-026 out_ready while not in DONE SHALL have no effect.
REQ-027 Minimum spacing between accepts SHALL be 6 cycles (accept, 4 MUL, 1 DONE).

Reset
REQ-028 While rst_n=0 at an edge: state=IDLE, step=0, accumulator=0, product=0, out_valid=0, busy=0, in_ready=1 after the edge, mul_x=mul_y=0.
REQ-029 Reset in MUL or DONE SHALL abort the operation; no out_valid for the aborted operation is produced.
REQ-030 in_valid with rst_n=0 SHALL NOT be accepted.

Verification
REQ-031 a=0xA5, b=0x3C accepted -> (mul_x,mul_y) = (5,C),(A,C),(5,3),(A,3) on successive MUL cycles; product=0x26AC with out_valid 4 cycles after accept.
REQ-032 a=0xFF, b=0xFF -> product=0xFE01; a=0x00, b=0xAB -> product=0x0000; a=0x12, b=0x34 -> product=0x03A8.
REQ-033 Backpressure: out_ready=0 for 3 cycles in DONE -> out_valid=1 and product constant throughout; IDLE one cycle after out_ready=1.
REQ-034 Reset mid-operation: rst_n=0 for one cycle at step2 -> next cycle state IDLE, in_ready=1, out_valid=0, product=0; a following op returns a correct product.
REQ-035 Back-to-back: in_valid held high with out_ready=1 -> accepts exactly 6 cycles apart; operand changes during MUL do not affect the product.
REQ-036 Random: 1000 random a,b pairs with random out_ready stalls -> every product equals a*b, in order, none lost or duplicated.
